lc3_mem_if: RTL and testbench

LC-3 memory interface stage: holds the MAR and MDR registers and runs the multi-cycle memory/MMIO access handshake. It sits directly downstream of the MARMUX and the other bus drivers. It captures addresses and data from the shared 16-bit bus, performs reads and writes against an external memory with a req/ack handshake, and returns read data to the bus through GateMDR. It reports completion to the control FSM via `r`.

---
 rtl/lc3_pkg.sv | 16 +
 rtl/lc3_mmio_regs.sv | 49 ++++
 rtl/lc3_mem_if.sv | 116 +++++++++++
 tb/tb_lc3_mem_if.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-interface definitions: MMIO register addresses and the
// access state machine encoding.
package lc3_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 memory-mapped I/O block: KBSR/KBDR/DSR/DDR decode, read mux, and the
// display character register with its keyboard/display strobes.
module lc3_mmio_regs
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        access,
  input  logic        rw,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  input  logic        dsp_ready,
  output logic        hit,
  output logic [15:0] rdata,
  output logic        kbd_taken,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data
);

  always_comb begin
    hit   = 1'b0;
    rdata = 16'h0000;
    case (addr)
      KBSR_ADDR: begin hit = 1'b1; rdata = {kbd_valid, 15'b0}; end
      KBDR_ADDR: begin hit = 1'b1; rdata = {8'h00, kbd_data}; end
      DSR_ADDR:  begin hit = 1'b1; rdata = {dsp_ready, 15'b0}; end
      DDR_ADDR:  begin hit = 1'b1; rdata = 16'h0000; end
      default:   begin hit = 1'b0; rdata = 16'h0000; end
    endcase
  end

  // An MMIO access spends exactly one cycle in ACCESS, so the strobes land
  // in the completion cycle alongside r.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kbd_taken <= 1'b0;
      dsp_valid <= 1'b0;
      dsp_data  <= 8'h00;
    end else begin
      kbd_taken <= access && !rw && (addr == KBDR_ADDR);
      dsp_valid <= access && rw && (addr == DDR_ADDR);
      if (access && rw && (addr == DDR_ADDR))
        dsp_data <= wdata;
    end
  end

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: MAR/MDR, req/ack access FSM, GateMDR bus driver.
// Build with LC3_MMIO_EN defined to decode the xFE00-xFE06 device registers.
module lc3_mem_if
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        gate_mdr,
  output logic [15:0] data_bus,
  output logic        r,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_taken,
  input  logic        dsp_ready,
  output logic [7:0]  dsp_data,
  output logic        dsp_valid,
  output state_t      state_dbg
);

  // Handshake: mem_req holds high from the first ACCESS cycle until the
  // cycle in which mem_ack is seen; the transfer completes on that edge and
  // mem_req/mem_we are meaningful only while mem_req is high.

  state_t      state;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        rw_q;
  logic        mmio_hit;
  logic [15:0] mmio_rdata;

`ifdef LC3_MMIO_EN
  lc3_mmio_regs u_mmio (
    .clk       (clk),
    .reset     (reset),
    .addr      (mar),
    .wdata     (mdr[7:0]),
    .access    (state == ACCESS),
    .rw        (rw_q),
    .kbd_data  (kbd_data),
    .kbd_valid (kbd_valid),
    .dsp_ready (dsp_ready),
    .hit       (mmio_hit),
    .rdata     (mmio_rdata),
    .kbd_taken (kbd_taken),
    .dsp_valid (dsp_valid),
    .dsp_data  (dsp_data)
  );
`else
  logic unused_mmio;
  assign unused_mmio = ^{kbd_data, kbd_valid, dsp_ready};
  assign mmio_hit    = 1'b0;
  assign mmio_rdata  = 16'h0000;
  assign kbd_taken   = 1'b0;
  assign dsp_valid   = 1'b0;
  assign dsp_data    = 8'h00;
`endif

  // Decoded from state so an asynchronous reset drops the request at once.
  assign mem_req   = (state == ACCESS) && !mmio_hit;
  assign mem_we    = mem_req && rw_q;
  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign data_bus  = gate_mdr ? mdr : 16'hzzzz;
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mar   <= 16'h0000;
      mdr   <= 16'h0000;
      rw_q  <= 1'b0;
      r     <= 1'b0;
    end else begin
      r <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_mar)
            mar <= bus_in;
          if (ld_mdr && !mio_en)
            mdr <= bus_in;
          if (mio_en) begin
            rw_q  <= r_w;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (mmio_hit) begin
            if (!rw_q)
              mdr <= mmio_rdata;
            r     <= 1'b1;
            state <= DONE;
          end else if (mem_ack) begin
            if (!rw_q)
              mdr <= mem_rdata;
            r     <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed self-checking bench for lc3_mem_if; expectations follow the
// LC3_MMIO_EN setting of the build.
module tb_lc3_mem_if;
  import lc3_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w, gate_mdr;
  wire  [15:0] data_bus;
  logic        r;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [7:0]  kbd_data;
  logic        kbd_valid, kbd_taken;
  logic        dsp_ready;
  logic [7:0]  dsp_data;
  logic        dsp_valid;
  state_t      state_dbg;

  int total_cnt = 0;
  int pass_cnt  = 0;

`ifdef LC3_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  lc3_mem_if dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .gate_mdr(gate_mdr), .data_bus(data_bus), .r(r),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .kbd_data(kbd_data),
    .kbd_valid(kbd_valid), .kbd_taken(kbd_taken), .dsp_ready(dsp_ready),
    .dsp_data(dsp_data), .dsp_valid(dsp_valid), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Starts an access at addr (MAR load and mio_en in the same cycle), acks
  // external memory in cycle 1+ack_delay, and reports what was seen up to and
  // including the cycle after r.
  task automatic run_access(input logic [15:0] addr, input logic rw, input int ack_delay,
                            input logic [15:0] rdata, output int r_cycle, output int req_cycles,
                            output int we_cycles, output int kbd_pulses, output int dsp_pulses,
                            output logic [15:0] bus_at_r);
    r_cycle = -1; req_cycles = 0; we_cycles = 0; kbd_pulses = 0; dsp_pulses = 0;
    bus_at_r = 16'h0000;
    bus_in = addr; ld_mar = 1'b1; mio_en = 1'b1; r_w = rw;
    step();
    ld_mar = 1'b0; mio_en = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      mem_ack   = (c >= 1 + ack_delay);
      mem_rdata = rdata;
      if (mem_req) req_cycles++;
      if (mem_req && mem_we) we_cycles++;
      if (kbd_taken) kbd_pulses++;
      if (dsp_valid) dsp_pulses++;
      if (r) begin
        r_cycle  = c;
        bus_at_r = data_bus;
        break;
      end
      step();
    end
    mem_ack = 1'b0;
    step();
    if (kbd_taken) kbd_pulses++;
    if (dsp_valid) dsp_pulses++;
  endtask

  int          rc, reqc, wec, kbdc, dspc, rpulses;
  logic [15:0] bus_r;

  initial begin
    reset = 1'b1; bus_in = '0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0;
    gate_mdr = 0; mem_rdata = '0; mem_ack = 0; kbd_data = '0; kbd_valid = 0; dsp_ready = 0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset_mar", mem_addr, 16'h0000);
    check("reset_mdr", mem_wdata, 16'h0000);
    check("reset_r", {15'b0, r}, 16'h0000);
    check("reset_req", {15'b0, mem_req}, 16'h0000);
    check("reset_strobes", {14'b0, kbd_taken, dsp_valid}, 16'h0000);
    check("reset_dsp_data", {8'h00, dsp_data}, 16'h0000);
    check("reset_state", {14'b0, state_dbg}, {14'b0, IDLE});

    // Zero-wait read of x3000
    gate_mdr = 1'b1;
    run_access(16'h3000, 1'b0, 0, 16'hBEEF, rc, reqc, wec, kbdc, dspc, bus_r);
    check("zw_read_r_cycle", rc[15:0], 16'd2);
    check("zw_read_req_cycles", reqc[15:0], 16'd1);
    check("zw_read_we_cycles", wec[15:0], 16'd0);
    check("zw_read_bus_at_r", bus_r, 16'hBEEF);
    check("zw_read_mdr", mem_wdata, 16'hBEEF);
    check("zw_read_mar", mem_addr, 16'h3000);
    check("zw_read_back_idle", {14'b0, state_dbg}, {14'b0, IDLE});
    gate_mdr = 1'b0;

    // Wait-state write of x1234 to x4000, with loads attempted while busy
    bus_in = 16'h4000; ld_mar = 1'b1; step();
    bus_in = 16'h1234; ld_mar = 1'b0; ld_mdr = 1'b1; step();
    ld_mdr = 1'b0;
    check("ws_setup_mar", mem_addr, 16'h4000);
    check("ws_setup_mdr", mem_wdata, 16'h1234);
    mio_en = 1'b1; r_w = 1'b1; step();
    mio_en = 1'b0; r_w = 1'b0;
    bus_in = 16'h5555; ld_mar = 1'b1; ld_mdr = 1'b1;
    wec = 0;
    check("ws_state_access", {14'b0, state_dbg}, {14'b0, ACCESS});
    for (int c = 1; c <= 4; c++) begin
      mem_ack = (c == 4);
      if (mem_req && mem_we) wec++;
      check("ws_r_low_while_waiting", {15'b0, r}, 16'h0000);
      step();
    end
    mem_ack = 1'b0;
    check("ws_req_we_cycles", wec[15:0], 16'd4);
    check("ws_r_after_ack", {15'b0, r}, 16'h0001);
    check("ws_req_dropped", {15'b0, mem_req}, 16'h0000);
    check("ignored_ld_mar", mem_addr, 16'h4000);
    check("ignored_ld_mdr", mem_wdata, 16'h1234);
    ld_mar = 1'b0; ld_mdr = 1'b0;
    step();
    check("ws_r_single_pulse", {15'b0, r}, 16'h0000);

    // KBDR read
    kbd_data = 8'h41; kbd_valid = 1'b1;
    run_access(KBDR_ADDR, 1'b0, 0, 16'h1111, rc, reqc, wec, kbdc, dspc, bus_r);
    check("kbdr_r_cycle", rc[15:0], 16'd2);
    check("kbdr_mdr", mem_wdata, MMIO ? 16'h0041 : 16'h1111);
    check("kbdr_req_cycles", reqc[15:0], MMIO ? 16'd0 : 16'd1);
    check("kbdr_taken_pulses", kbdc[15:0], MMIO ? 16'd1 : 16'd0);

    // KBSR and DSR reads
    run_access(KBSR_ADDR, 1'b0, 0, 16'h2222, rc, reqc, wec, kbdc, dspc, bus_r);
    check("kbsr_mdr", mem_wdata, MMIO ? 16'h8000 : 16'h2222);
    check("kbsr_no_taken", kbdc[15:0], 16'd0);
    dsp_ready = 1'b0;
    run_access(DSR_ADDR, 1'b0, 1, 16'h3333, rc, reqc, wec, kbdc, dspc, bus_r);
    check("dsr_busy_mdr", mem_wdata, MMIO ? 16'h0000 : 16'h3333);
    check("dsr_busy_r_cycle", rc[15:0], MMIO ? 16'd2 : 16'd3);
    dsp_ready = 1'b1;
    run_access(DSR_ADDR, 1'b0, 0, 16'h4444, rc, reqc, wec, kbdc, dspc, bus_r);
    check("dsr_ready_mdr", mem_wdata, MMIO ? 16'h8000 : 16'h4444);

    // DDR write
    bus_in = 16'h0A5A; ld_mdr = 1'b1; step(); ld_mdr = 1'b0;
    run_access(DDR_ADDR, 1'b1, 0, 16'h0000, rc, reqc, wec, kbdc, dspc, bus_r);
    check("ddr_r_cycle", rc[15:0], 16'd2);
    check("ddr_dsp_data", {8'h00, dsp_data}, MMIO ? 16'h005A : 16'h0000);
    check("ddr_dsp_pulses", dspc[15:0], MMIO ? 16'd1 : 16'd0);
    check("ddr_req_cycles", reqc[15:0], MMIO ? 16'd0 : 16'd1);
    check("ddr_we_cycles", wec[15:0], MMIO ? 16'd0 : 16'd1);
    check("ddr_mdr_kept", mem_wdata, 16'h0A5A);

    // DDR read returns zero
    run_access(DDR_ADDR, 1'b0, 0, 16'h5555, rc, reqc, wec, kbdc, dspc, bus_r);
    check("ddr_read_mdr", mem_wdata, MMIO ? 16'h0000 : 16'h5555);

    // Reset in the middle of an un-acked external access
    bus_in = 16'h6000; ld_mar = 1'b1; mio_en = 1'b1; r_w = 1'b0; step();
    ld_mar = 1'b0; mio_en = 1'b0;
    check("rst_mid_req_before", {15'b0, mem_req}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_req_dropped", {15'b0, mem_req}, 16'h0000);
    check("rst_mid_mar", mem_addr, 16'h0000);
    check("rst_mid_mdr", mem_wdata, 16'h0000);
    check("rst_mid_dsp_data", {8'h00, dsp_data}, 16'h0000);
    step();
    reset = 1'b0;
    mem_ack = 1'b1;
    rpulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (r) rpulses++;
      step();
    end
    mem_ack = 1'b0;
    check("rst_mid_no_r", rpulses[15:0], 16'd0);
    check("rst_mid_idle", {14'b0, state_dbg}, {14'b0, IDLE});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
